// File: rtl/mpt_walk_arbiter.sv
// Round-robin arbiter sharing one MPT walker among NUM_REQ requesters.
// One transaction in flight; bypass modes answer without using the walker.
package mpt_walk_pkg;
  typedef enum logic {MPT_WALKING_DO = 1'b0, MPT_WALKING_SKIP = 1'b1} mpt_walking_e;
  typedef enum logic [3:0] {MPT_BARE = 4'd0, MPT_34 = 4'd1, MPT_43 = 4'd2, MPT_52 = 4'd3} mpt_mode_e;
  typedef enum logic [2:0] {
    NO_ERROR = 3'd0, ILLEGAL_ENTRY = 3'd1, NOT_VALID_ENTRY = 3'd2, ACCESS_FAULT = 3'd3
  } page_format_fault_e;
  typedef struct packed {
    mpt_walking_e walking;
    mpt_mode_e    mode;
    logic [5:0]   sdid;
    logic [1:0]   access;
    logic [33:0]  spa;
  } mptw_transaction_t;
endpackage

module mpt_walk_arbiter
  import mpt_walk_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  input  logic              [NUM_REQ-1:0]  req_valid_i,
  output logic              [NUM_REQ-1:0]  req_ready_o,
  input  mptw_transaction_t [NUM_REQ-1:0]  req_trans_i,
  output logic              [NUM_REQ-1:0]  rsp_valid_o,
  output logic                             rsp_allow_o,
  output logic                             rsp_fault_o,
  output logic              [2:0]          rsp_cause_o,
  output logic                             walk_valid_o,
  input  logic                             walk_ready_i,
  output mptw_transaction_t                walk_trans_o,
  input  logic                             walk_done_i,
  input  logic                             walk_allow_i,
  input  logic                             walk_fault_i,
  input  logic              [2:0]          walk_cause_i
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RSP, S_RESPOND} state_e;

  state_e            r_state, w_state_nxt;
  logic [IW-1:0]     r_ptr, r_idx, w_win, w_ptr_nxt;
  logic              r_drop, r_allow, r_fault;
  logic [2:0]        r_cause;
  mptw_transaction_t r_trans;
  logic              w_found, w_grant, w_bypass, w_walk_valid, w_rsp_valid, w_rsp_on;
  logic [NUM_REQ-1:0] w_ready;
  logic [IW:0]       w_k;

  // Round-robin search from r_ptr upward, wrapping at NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_k = {1'b0, r_ptr} + (IW+1)'(i);
      if (w_k >= (IW+1)'(NUM_REQ)) w_k = w_k - (IW+1)'(NUM_REQ);
      if (!w_found && req_valid_i[w_k[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_k[IW-1:0];
      end
    end
  end

  assign w_ptr_nxt = (w_win == IW'(NUM_REQ-1)) ? '0 : w_win + IW'(1);
  assign w_bypass  = (req_trans_i[w_win].walking == MPT_WALKING_SKIP) ||
                     (req_trans_i[w_win].mode == MPT_BARE);

  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    w_ready      = '0;
    w_walk_valid = 1'b0;
    w_rsp_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found && !flush_i) begin
          w_grant        = 1'b1;
          w_ready[w_win] = 1'b1;
          w_state_nxt    = w_bypass ? S_RESPOND : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Once the walker accepts, it owns the transaction even under flush.
        w_walk_valid = 1'b1;
        if (walk_ready_i) w_state_nxt = S_WAIT_RSP;
        else if (flush_i) w_state_nxt = S_IDLE;
      end
      S_WAIT_RSP: begin
        if (walk_done_i) w_state_nxt = (r_drop || flush_i) ? S_IDLE : S_RESPOND;
      end
      S_RESPOND: begin
        w_rsp_valid = !flush_i;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_drop  <= 1'b0;
      r_allow <= 1'b0;
      r_fault <= 1'b0;
      r_cause <= '0;
      r_trans <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_idx   <= w_win;
        r_ptr   <= w_ptr_nxt;
        r_trans <= req_trans_i[w_win];
        // Bypass result; overwritten by the walker result otherwise.
        r_allow <= 1'b1;
        r_fault <= 1'b0;
        r_cause <= NO_ERROR;
      end
      if (r_state == S_WAIT_RSP && walk_done_i) begin
        r_allow <= walk_allow_i;
        r_fault <= walk_fault_i;
        r_cause <= walk_cause_i;
      end
      if (w_state_nxt == S_IDLE)
        r_drop <= 1'b0;
      else if (flush_i && ((r_state == S_ISSUE && walk_ready_i) || r_state == S_WAIT_RSP))
        r_drop <= 1'b1;
    end
  end

  assign w_rsp_on     = w_rsp_valid && !rst_i;
  assign req_ready_o  = rst_i ? '0 : w_ready;
  assign rsp_valid_o  = w_rsp_on ? (NUM_REQ'(1) << r_idx) : '0;
  assign rsp_allow_o  = w_rsp_on && r_allow;
  assign rsp_fault_o  = w_rsp_on && r_fault;
  assign rsp_cause_o  = w_rsp_on ? r_cause : '0;
  assign walk_valid_o = w_walk_valid && !rst_i;
  assign walk_trans_o = rst_i ? '0 : r_trans;
endmodule

// File: tb/tb_mpt_walk_arbiter.sv
// Directed bench for mpt_walk_arbiter; responses checked against a scoreboard queue.
module tb_mpt_walk_arbiter;
  import mpt_walk_pkg::*;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [1:0] req_valid = '0, req_ready, rsp_valid;
  mptw_transaction_t [1:0] req_trans;
  logic rsp_allow, rsp_fault, walk_valid, walk_ready = 1'b0;
  logic [2:0] rsp_cause, walk_cause = '0;
  mptw_transaction_t walk_trans;
  logic walk_done = 1'b0, walk_allow = 1'b0, walk_fault = 1'b0;

  int total = 0, bad = 0;
  logic [6:0] sb[$];

  always #5 clk = ~clk;

  mpt_walk_arbiter #(.NUM_REQ(2)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_trans_i(req_trans),
    .rsp_valid_o(rsp_valid), .rsp_allow_o(rsp_allow), .rsp_fault_o(rsp_fault),
    .rsp_cause_o(rsp_cause), .walk_valid_o(walk_valid), .walk_ready_i(walk_ready),
    .walk_trans_o(walk_trans), .walk_done_i(walk_done), .walk_allow_i(walk_allow),
    .walk_fault_i(walk_fault), .walk_cause_i(walk_cause)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid != 2'b00) begin
        if (sb.size() == 0) chk("rsp_unexpected", 64'({rsp_valid, rsp_allow, rsp_fault, rsp_cause}), 64'd0);
        else chk("rsp", 64'({rsp_valid, rsp_allow, rsp_fault, rsp_cause}), 64'(sb.pop_front()));
      end else begin
        chk("rsp_idle_zero", 64'({rsp_allow, rsp_fault, rsp_cause}), 64'd0);
      end
    end
  end

  task automatic walk(input logic [1:0] vld, input logic [1:0] exp_g, input logic a, input logic f,
                      input logic [2:0] c, input int dly);
    req_valid = vld;
    #1 chk("grant", 64'(req_ready), 64'(exp_g));
    sb.push_back({exp_g, a, f, c});
    tick();
    chk("issue_wv", 64'(walk_valid), 64'd1);
    chk("issue_trans", 64'(walk_trans), exp_g[1] ? 64'(req_trans[1]) : 64'(req_trans[0]));
    chk("issue_rdy", 64'(req_ready), 64'd0);
    walk_ready = 1'b1;
    tick();
    walk_ready = 1'b0;
    #1 chk("wait_wv", 64'(walk_valid), 64'd0);
    repeat (dly - 1) tick();
    {walk_done, walk_allow, walk_fault, walk_cause} = {1'b1, a, f, c};
    tick();
    {walk_done, walk_allow, walk_fault, walk_cause} = '0;
    #1 chk("respond_rdy", 64'(req_ready), 64'd0);
    tick();
  endtask

  task automatic bypass(input logic [1:0] vld, input logic [1:0] exp_g);
    req_valid = vld;
    #1 chk("byp_grant", 64'(req_ready), 64'(exp_g));
    sb.push_back({exp_g, 1'b1, 1'b0, 3'b000});
    tick();
    req_valid = '0;
    #1 chk("byp_wv", 64'(walk_valid), 64'd0);
    chk("byp_rsp", 64'(rsp_valid), 64'(exp_g));
    tick();
  endtask

  initial begin
    req_trans[0] = '{walking: MPT_WALKING_DO, mode: MPT_43, sdid: 6'h05, access: 2'b01, spa: 34'h1_2345_6789};
    req_trans[1] = '{walking: MPT_WALKING_DO, mode: MPT_43, sdid: 6'h2a, access: 2'b10, spa: 34'h2_abcd_ef01};
    // Reset: outputs held low even with a request pending
    req_valid = 2'b01;
    tick(); tick();
    chk("rst_rdy", 64'(req_ready), 64'd0);
    chk("rst_rsp", 64'({rsp_valid, rsp_allow, rsp_fault, rsp_cause}), 64'd0);
    chk("rst_walk", 64'({walk_valid, walk_trans}), 64'd0);
    rst = 1'b0; req_valid = '0;
    tick();

    // Round-robin with both requesters held, then a fault
    walk(2'b11, 2'b01, 1'b1, 1'b0, 3'b000, 3);
    walk(2'b11, 2'b10, 1'b1, 1'b0, 3'b000, 3);
    walk(2'b11, 2'b01, 1'b1, 1'b0, 3'b000, 3);
    walk(2'b11, 2'b10, 1'b0, 1'b1, NOT_VALID_ENTRY, 2);
    req_valid = '0;

    // Bypass: walking skip on req0, bare mode on req1
    req_trans[0].walking = MPT_WALKING_SKIP;
    bypass(2'b01, 2'b01);
    req_trans[0].walking = MPT_WALKING_DO;
    req_trans[1].mode = MPT_BARE;
    bypass(2'b10, 2'b10);
    req_trans[1].mode = MPT_43;

    // Flush in WAIT_RSP: response dropped, grant returns after done
    req_valid = 2'b01; tick(); req_valid = '0;
    walk_ready = 1'b1; tick(); walk_ready = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (3) tick();
    req_valid = 2'b01; walk_done = 1'b1; walk_allow = 1'b1;
    #1 chk("fwait_rdy_done", 64'(req_ready), 64'd0);
    tick();
    walk_done = 1'b0; walk_allow = 1'b0;
    #1 chk("fwait_rdy_after", 64'(req_ready), 64'd1);
    req_valid = '0; tick();

    // Flush coinciding with walker acceptance (prio now at req1)
    req_valid = 2'b11;
    #1 chk("facc_grant", 64'(req_ready), 64'd2);
    tick(); req_valid = '0;
    walk_ready = 1'b1; flush = 1'b1; tick(); walk_ready = 1'b0; flush = 1'b0;
    tick();
    walk_done = 1'b1; walk_allow = 1'b1; tick(); walk_done = 1'b0; walk_allow = 1'b0;

    // Flush in ISSUE without acceptance
    req_valid = 2'b01; tick(); req_valid = '0;
    flush = 1'b1;
    #1 chk("fiss_wv_same", 64'(walk_valid), 64'd1);
    tick(); flush = 1'b0;
    req_valid = 2'b01;
    #1 chk("fiss_wv_next", 64'(walk_valid), 64'd0);
    chk("fiss_idle_rdy", 64'(req_ready), 64'd1);
    req_valid = '0; tick();

    // Flush in RESPOND suppresses the bypass response
    req_trans[1].mode = MPT_BARE;
    req_valid = 2'b10; tick(); req_valid = '0;
    flush = 1'b1;
    #1 chk("fresp_rsp", 64'(rsp_valid), 64'd0);
    tick(); flush = 1'b0;
    req_trans[1].mode = MPT_43;

    // walk_done together with flush
    req_valid = 2'b01; tick(); req_valid = '0;
    walk_ready = 1'b1; tick(); walk_ready = 1'b0;
    tick();
    walk_done = 1'b1; walk_allow = 1'b1; flush = 1'b1; tick();
    walk_done = 1'b0; walk_allow = 1'b0; flush = 1'b0;

    // Flush in IDLE blocks the grant; stale done in IDLE is ignored
    req_valid = 2'b01; flush = 1'b1;
    #1 chk("fidle_rdy", 64'(req_ready), 64'd0);
    tick(); flush = 1'b0; req_valid = '0;
    walk_done = 1'b1; walk_allow = 1'b1; tick(); walk_done = 1'b0; walk_allow = 1'b0;
    tick();

    // Reset mid-walk (prio at req1 before reset), stale done after release
    req_valid = 2'b01; tick(); req_valid = '0;
    walk_ready = 1'b1; tick(); walk_ready = 1'b0;
    rst = 1'b1; req_valid = 2'b11;
    #1 chk("mrst_out", 64'({req_ready, rsp_valid, rsp_allow, rsp_fault, rsp_cause, walk_valid}), 64'd0);
    chk("mrst_trans", 64'(walk_trans), 64'd0);
    tick(); tick();
    req_valid = '0; rst = 1'b0;
    walk_done = 1'b1; walk_allow = 1'b1; tick(); walk_done = 1'b0; walk_allow = 1'b0;
    walk(2'b11, 2'b01, 1'b1, 1'b0, 3'b000, 2);
    req_valid = '0;
    repeat (3) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mpt_walk_arbiter.md
MPT_WALK_ARBITER -- requirements
Module: mpt_walk_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, SHALL set the number of requesters sharing the single MPT walker (legal range 2..8).
REQ-002 Port clk_i, input, 1: the block's single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_i, input, 1: reset; synchronous, active-high.
REQ-004 Port flush_i, input, 1: abort the in-flight transaction and drop its response.
REQ-005 Port req_valid_i, input, NUM_REQ: per-requester request valid.
REQ-006 Port req_ready_o, output, NUM_REQ: per-requester grant; at most one bit set per cycle.
REQ-007 Port req_trans_i, input, NUM_REQ x $bits(mptw_transaction_t): per-requester transaction.
REQ-008 Port rsp_valid_o, output, NUM_REQ: one-cycle response pulse to the owning requester.
REQ-009 Port rsp_allow_o, output, 1: access permitted.
REQ-010 Port rsp_fault_o, output, 1: access faulted.
REQ-011 Port rsp_cause_o, output, 3 (page_format_fault_e): fault cause.
REQ-012 Port walk_valid_o, output, 1: transaction offered to the walker.
REQ-013 Port walk_ready_i, input, 1: walker accepts the transaction.
REQ-014 Port walk_trans_o, output, $bits(mptw_transaction_t): latched transaction.
REQ-015 Port walk_done_i, input, 1: walker result valid (single-cycle pulse).
REQ-016 Ports walk_allow_i, walk_fault_i (1 bit each) and walk_cause_i (3 bits), inputs: walker result, sampled only when walk_done_i=1.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT_RSP and RESPOND; only one transaction SHALL be in flight.
REQ-018 IDLE: if any req_valid_i bit is set, set req_ready_o for the round-robin winner in the same cycle (combinational), latch its transaction and index at the clock edge, and leave IDLE.
REQ-019 Round-robin: search starts at prio_ptr, ascending with wrap from NUM_REQ-1 to 0; after each grant, prio_ptr = winner+1 mod NUM_REQ.
REQ-020 Bypass: if the latched walking=MPT_WALKING_SKIP or MODE=MPT_BARE, go IDLE->RESPOND with allow=1, fault=0, cause=NO_ERROR; the walker is not used.
REQ-021 Otherwise go IDLE->ISSUE; walk_valid_o=1 throughout ISSUE with walk_trans_o stable; on walk_valid_o && walk_ready_i go to WAIT_RSP.
REQ-022 WAIT_RSP: on walk_done_i, latch allow/fault/cause and go to RESPOND.
REQ-023 RESPOND: rsp_valid_o[owner]=1 for exactly one cycle with the latched result, then go to IDLE; no new grant is made in RESPOND.
REQ-024 req_ready_o SHALL be 0 in every state except IDLE.
REQ-025 rsp_allow_o, rsp_fault_o and rsp_cause_o SHALL be 0 whenever rsp_valid_o=0.
REQ-026 Flush in IDLE: no grant that cycle.
REQ-027 Flush in ISSUE with no walker acceptance: deassert walk_valid_o and go to IDLE next cycle.
REQ-028 Flush in ISSUE coinciding with walk_ready_i: the walker owns the transaction; go to WAIT_RSP with a drop flag set.
REQ-029 Flush in WAIT_RSP: set the drop flag and stay in WAIT_RSP until walk_done_i, then go to IDLE with no response.
REQ-030 walk_done_i and flush_i in the same cycle: the response is dropped and the FSM goes to IDLE.
REQ-031 Flush in RESPOND: suppress rsp_valid_o and go to IDLE.
REQ-032 The drop flag SHALL clear on entry to IDLE.
REQ-033 walk_done_i outside WAIT_RSP SHALL be ignored.
REQ-034 Latency (bypass): grant in cycle T, response in T+1.
REQ-035 Latency (walk): grant in T, walk_valid_o from T+1, response one cycle after walk_done_i.

Reset
REQ-036 While rst_i=1: state=IDLE, prio_ptr=0, drop flag=0, latched index/result/transaction=0.
REQ-037 While rst_i=1: all outputs 0, including req_ready_o, rsp_valid_o, walk_valid_o and walk_trans_o.
REQ-038 Reset mid-walk abandons the transaction; a stale walk_done_i after reset SHALL be ignored per REQ-033.

Verification
REQ-039 Bypass: NUM_REQ=2, req_valid_i=2'b01, walking=SKIP -> req_ready_o=01 in cycle T; rsp_valid_o=01, allow=1, cause=0 in T+1; walk_valid_o never 1.
REQ-040 Round-robin: req_valid_i=2'b11 held, MODE=MPT_43, walker ready=1, done 3 cycles later -> grants alternate 01,10,01; responses routed to the matching bit.
REQ-041 Fault: walk_done_i with fault=1, cause=NOT_VALID_ENTRY (3'b010) -> rsp_fault_o=1, rsp_cause_o=3'b010, allow=0 for one cycle.
REQ-042 Flush in WAIT_RSP, walk_done_i 4 cycles later -> no rsp_valid_o; req_ready_o reasserts the cycle after walk_done_i.
REQ-043 Flush in ISSUE with walk_ready_i=0 -> walk_valid_o=0 next cycle; FSM in IDLE; no response.
REQ-044 rst_i asserted in WAIT_RSP, then walk_done_i after release -> all outputs 0; no response; the next request is granted normally with prio_ptr=0.
